fetch_pc_unit: RTL

- Owns the program counter and the instruction-memory fetch handshake for the basic pipeline.
- Drives the current fetch address to the sequential-address adder.
- Consumes the next address that the address-select mux computes from it and from EX/MA, and loads the PC with that address.
- Presents fetched instructions to the IF/ID register through a one-slot output with a skid buffer, and absorbs downstream stall and redirect/flush.

---
 rtl/fetch_pc_unit_pkg.sv | 19 +
 rtl/fetch_skid_slot.sv | 75 +++++++
 rtl/fetch_pc_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage definitions: address width, reset vector and the
// fetch controller state encoding.
package fetch_pc_unit_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_ADDR = 32'h0000_0000;

    // IDLE: waiting one cycle after reset before the first request
    // REQ : request to FetchAddr is live
    // SKID: output slot and skid both full, no request until drained
    // DROP: redirected while a request was outstanding; finish it, discard data
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SKID = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_slot.sv
// One-entry output slot towards IF/ID backed by a single skid entry.
// The slot is what downstream sees; the skid holds the word that returned
// while the slot was stalled, and is promoted into the slot once it drains.
module fetch_skid_slot
    import fetch_pc_unit_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load_slot,
    input  logic              load_skid,
    input  logic              promote,
    input  logic              stall,
    input  logic [ADDR_W-1:0] data,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] slot_instr,
    output logic [ADDR_W-1:0] slot_pc,
    output logic              slot_valid,
    output logic              slot_free,
    output logic              slot_consumed
);

    logic [ADDR_W-1:0] slot_instr_r;
    logic [ADDR_W-1:0] slot_pc_r;
    logic              slot_valid_r;
    logic [ADDR_W-1:0] skid_instr_r;
    logic [ADDR_W-1:0] skid_pc_r;
    logic              skid_valid_r;

    assign slot_instr    = slot_instr_r;
    assign slot_pc       = slot_pc_r;
    assign slot_valid    = slot_valid_r;
    assign slot_consumed = slot_valid_r & ~stall;
    assign slot_free     = ~slot_valid_r | ~stall;

    // Slot and skid registers: flush beats promote beats new load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_instr_r <= {ADDR_W{1'b0}};
            slot_pc_r    <= {ADDR_W{1'b0}};
            slot_valid_r <= 1'b0;
            skid_instr_r <= {ADDR_W{1'b0}};
            skid_pc_r    <= {ADDR_W{1'b0}};
            skid_valid_r <= 1'b0;
        end else if (flush) begin
            slot_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (promote) begin
            slot_instr_r <= skid_instr_r;
            slot_pc_r    <= skid_pc_r;
            slot_valid_r <= skid_valid_r;
            skid_valid_r <= 1'b0;
        end else begin
            if (load_slot) begin
                slot_instr_r <= data;
                slot_pc_r    <= pc;
                slot_valid_r <= 1'b1;
            end else if (slot_consumed) begin
                slot_valid_r <= 1'b0;
            end else begin
                slot_valid_r <= slot_valid_r;
            end
            if (load_skid) begin
                skid_instr_r <= data;
                skid_pc_r    <= pc;
                skid_valid_r <= 1'b1;
            end else begin
                skid_valid_r <= skid_valid_r;
            end
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: holds the program counter, runs the instruction-memory
// request handshake and feeds IF/ID through a skid-buffered output slot.
// Redirects from EX/MA flush buffered work; a redirect arriving while a
// request is still outstanding lets that request finish and drops its data.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int                ADDR_W     = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = FETCH_RESET_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] NextAddrIn,
    input  logic              RedirectIn,
    input  logic              StallIn,
    output logic [ADDR_W-1:0] FetchAddrOut,
    output logic              IMemReqOut,
    output logic [ADDR_W-1:0] IMemAddrOut,
    input  logic              IMemRdyIn,
    input  logic [ADDR_W-1:0] IMemDataIn,
    output logic [ADDR_W-1:0] InstrOut,
    output logic [ADDR_W-1:0] PCOut,
    output logic              ValidOut
);

    fetch_state_e      state_r;
    fetch_state_e      state_nxt_s;
    logic [ADDR_W-1:0] fetch_addr_r;
    logic [ADDR_W-1:0] fetch_addr_nxt_s;
    logic [ADDR_W-1:0] target_addr_r;
    logic [ADDR_W-1:0] target_addr_nxt_s;
    logic              load_slot_s;
    logic              load_skid_s;
    logic              promote_s;
    logic              flush_s;
    logic              slot_free_s;
    logic              slot_consumed_s;

    assign FetchAddrOut = fetch_addr_r;
    assign IMemAddrOut  = fetch_addr_r;
    assign IMemReqOut   = (state_r == REQ) || (state_r == DROP);

    // Next-state, next-PC and slot control; redirect takes priority.
    always_comb begin
        state_nxt_s       = state_r;
        fetch_addr_nxt_s  = fetch_addr_r;
        target_addr_nxt_s = target_addr_r;
        load_slot_s       = 1'b0;
        load_skid_s       = 1'b0;
        promote_s         = 1'b0;
        flush_s           = 1'b0;
        if (RedirectIn) begin
            flush_s = 1'b1;
            case (state_r)
                IDLE, SKID: begin
                    fetch_addr_nxt_s = NextAddrIn;
                    state_nxt_s      = REQ;
                end
                REQ: begin
                    if (IMemRdyIn) begin
                        fetch_addr_nxt_s = NextAddrIn;
                    end else begin
                        target_addr_nxt_s = NextAddrIn;
                        state_nxt_s       = DROP;
                    end
                end
                DROP: begin
                    target_addr_nxt_s = NextAddrIn;
                    if (IMemRdyIn) begin
                        fetch_addr_nxt_s = NextAddrIn;
                        state_nxt_s      = REQ;
                    end else begin
                        state_nxt_s = DROP;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end else begin
            case (state_r)
                IDLE: state_nxt_s = REQ;
                REQ: begin
                    if (IMemRdyIn) begin
                        fetch_addr_nxt_s = NextAddrIn;
                        if (slot_free_s) begin
                            load_slot_s = 1'b1;
                        end else begin
                            load_skid_s = 1'b1;
                            state_nxt_s = SKID;
                        end
                    end else begin
                        state_nxt_s = REQ;
                    end
                end
                SKID: begin
                    if (slot_consumed_s) begin
                        promote_s   = 1'b1;
                        state_nxt_s = REQ;
                    end else begin
                        state_nxt_s = SKID;
                    end
                end
                DROP: begin
                    if (IMemRdyIn) begin
                        fetch_addr_nxt_s = target_addr_r;
                        state_nxt_s      = REQ;
                    end else begin
                        state_nxt_s = DROP;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State, PC and redirect-target registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            fetch_addr_r  <= RESET_ADDR;
            target_addr_r <= {ADDR_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            fetch_addr_r  <= fetch_addr_nxt_s;
            target_addr_r <= target_addr_nxt_s;
        end
    end

    fetch_skid_slot #(
        .ADDR_W(ADDR_W)
    ) u_slot (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush_s),
        .load_slot    (load_slot_s),
        .load_skid    (load_skid_s),
        .promote      (promote_s),
        .stall        (StallIn),
        .data         (IMemDataIn),
        .pc           (fetch_addr_r),
        .slot_instr   (InstrOut),
        .slot_pc      (PCOut),
        .slot_valid   (ValidOut),
        .slot_free    (slot_free_s),
        .slot_consumed(slot_consumed_s)
    );

endmodule
